seg7_scan_pwm: RTL

- Parametrised multiplexed 7-segment driver; successor to the fixed 4-digit scanner.
- Supports N digits and configurable anode/segment polarity.
- Adds per-digit enable, an anti-ghosting blank interval and global PWM brightness.
- Takes new display data through a load strobe and applies it only at frame boundaries, so the display never tears.
- Sits between the display formatter (segment patterns) and the board pins.

---
 rtl/seg7_pkg.sv | 65 ++++++
 rtl/seg7_slot_timer.sv | 49 ++++
 rtl/seg7_scan_pwm.sv | 136 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment driver: polarity defaults,
// inactive-level helpers and the standard hex digit patterns (bit7 = dp).
package seg7_pkg;

    localparam bit AN_ACTIVE_LOW_DEFAULT  = 1'b0;
    localparam bit SEG_ACTIVE_LOW_DEFAULT = 1'b1;
    localparam int MAX_DIGITS             = 64;

    // Patterns are active-high, segment a in bit0 through g in bit6.
    localparam logic [7:0] SEG_PAT_0     = 8'h3F;
    localparam logic [7:0] SEG_PAT_1     = 8'h06;
    localparam logic [7:0] SEG_PAT_2     = 8'h5B;
    localparam logic [7:0] SEG_PAT_3     = 8'h4F;
    localparam logic [7:0] SEG_PAT_4     = 8'h66;
    localparam logic [7:0] SEG_PAT_5     = 8'h6D;
    localparam logic [7:0] SEG_PAT_6     = 8'h7D;
    localparam logic [7:0] SEG_PAT_7     = 8'h07;
    localparam logic [7:0] SEG_PAT_8     = 8'h7F;
    localparam logic [7:0] SEG_PAT_9     = 8'h6F;
    localparam logic [7:0] SEG_PAT_A     = 8'h77;
    localparam logic [7:0] SEG_PAT_B     = 8'h7C;
    localparam logic [7:0] SEG_PAT_C     = 8'h39;
    localparam logic [7:0] SEG_PAT_D     = 8'h5E;
    localparam logic [7:0] SEG_PAT_E     = 8'h79;
    localparam logic [7:0] SEG_PAT_F     = 8'h71;
    localparam logic [7:0] SEG_PAT_BLANK = 8'h00;

    // Inactive anode level for every digit; only the low num_digits bits matter.
    function automatic logic [MAX_DIGITS-1:0] an_off(input int num_digits, input bit active_low);
        logic [MAX_DIGITS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < num_digits) m[i] = active_low;
        end
        return m;
    endfunction

    function automatic logic [7:0] seg_off(input bit active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] p;
        case (nib)
            4'h0: p = SEG_PAT_0;
            4'h1: p = SEG_PAT_1;
            4'h2: p = SEG_PAT_2;
            4'h3: p = SEG_PAT_3;
            4'h4: p = SEG_PAT_4;
            4'h5: p = SEG_PAT_5;
            4'h6: p = SEG_PAT_6;
            4'h7: p = SEG_PAT_7;
            4'h8: p = SEG_PAT_8;
            4'h9: p = SEG_PAT_9;
            4'hA: p = SEG_PAT_A;
            4'hB: p = SEG_PAT_B;
            4'hC: p = SEG_PAT_C;
            4'hD: p = SEG_PAT_D;
            4'hE: p = SEG_PAT_E;
            default: p = SEG_PAT_F;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Digit slot timer: cnt counts cycles within a slot, pos selects the digit.
// frame_end marks the last cycle of the last digit's slot.
module seg7_slot_timer #(
    parameter int SCAN_DIV   = 625000,
    parameter int NUM_DIGITS = 4,
    localparam int CNT_W     = $clog2(SCAN_DIV),
    localparam int POS_W     = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic [POS_W-1:0] pos,
    output logic             frame_end,
    output logic             slot_start
);
    import seg7_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] pos_q, pos_d;

    // pos wraps explicitly so non-power-of-2 digit counts work.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        pos_d = pos_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            pos_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            pos_q <= pos_d;
        end
    end

    assign cnt        = cnt_q;
    assign pos        = pos_q;
    assign frame_end  = (cnt_q == CNT_LAST) && (pos_q == POS_LAST);
    assign slot_start = (cnt_q == '0);

endmodule

// File: rtl/seg7_scan_pwm.sv
// Multiplexed N-digit 7-segment driver with frame-aligned staging, per-digit
// enable, blank interval at slot start and PWM brightness.
module seg7_scan_pwm #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 625000,
    parameter int BLANK_CYC      = 2,
    parameter int BRIGHT_W       = 4,
    parameter bit AN_ACTIVE_LOW  = seg7_pkg::AN_ACTIVE_LOW_DEFAULT,
    parameter bit SEG_ACTIVE_LOW = seg7_pkg::SEG_ACTIVE_LOW_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*NUM_DIGITS-1:0] digit_codes,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg_code,
    output logic                    frame_start
);
    import seg7_pkg::*;

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int POS_W = $clog2(NUM_DIGITS);

    localparam logic [MAX_DIGITS-1:0] AN_OFF_W = an_off(NUM_DIGITS, AN_ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_OFF_W[NUM_DIGITS-1:0];
    localparam logic [7:0]            SEG_OFF  = seg_off(SEG_ACTIVE_LOW);
    localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt;
    logic [POS_W-1:0] pos;
    logic             frame_end;
    logic             slot_start;

    seg7_slot_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .NUM_DIGITS(NUM_DIGITS)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .pos       (pos),
        .frame_end (frame_end),
        .slot_start(slot_start)
    );

    // Staging: pending holds the latest load, active is what is displayed.
    logic [NUM_DIGITS-1:0][7:0] pend_code_q, pend_code_d;
    logic [NUM_DIGITS-1:0]      pend_en_q, pend_en_d;
    logic                       pend_q, pend_d;
    logic [NUM_DIGITS-1:0][7:0] act_code_q, act_code_d;
    logic [NUM_DIGITS-1:0]      act_en_q, act_en_d;

    always_comb begin
        pend_code_d = pend_code_q;
        pend_en_d   = pend_en_q;
        pend_d      = pend_q;
        act_code_d  = act_code_q;
        act_en_d    = act_en_q;
        if (load) begin
            pend_code_d = digit_codes;
            pend_en_d   = digit_en;
            pend_d      = 1'b1;
        end
        // A load in the boundary cycle bypasses pending so it is not a frame late.
        if (frame_end) begin
            if (load) begin
                act_code_d = digit_codes;
                act_en_d   = digit_en;
                pend_d     = 1'b0;
            end else if (pend_q) begin
                act_code_d = pend_code_q;
                act_en_d   = pend_en_q;
                pend_d     = 1'b0;
            end
        end
    end

    // Low cnt bits form the PWM ramp; zero-extend if the slot is shorter than the ramp.
    logic [BRIGHT_W-1:0] cnt_lsb;
    generate
        if (BRIGHT_W <= CNT_W) begin : g_lsb_slice
            assign cnt_lsb = cnt[BRIGHT_W-1:0];
        end else begin : g_lsb_ext
            assign cnt_lsb = BRIGHT_W'(cnt);
        end
    endgenerate

    logic                  lit;
    logic [NUM_DIGITS-1:0] an_hot;
    logic [NUM_DIGITS-1:0] an_d, an_q;
    logic [7:0]            seg_d, seg_q;
    logic                  frame_start_d, frame_start_q;

    always_comb begin
        lit = act_en_q[pos]
              && (cnt >= BLANK_END)
              && ((brightness == '1) || (cnt_lsb < brightness));
        an_hot = NUM_DIGITS'(1) << pos;
        an_d   = AN_OFF;
        seg_d  = SEG_OFF;
        if (lit) begin
            an_d  = an_hot ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
            seg_d = act_code_q[pos] ^ {8{SEG_ACTIVE_LOW}};
        end
        frame_start_d = slot_start && (pos == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_code_q   <= '0;
            pend_en_q     <= '0;
            pend_q        <= 1'b0;
            act_code_q    <= '0;
            act_en_q      <= '0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            pend_code_q   <= pend_code_d;
            pend_en_q     <= pend_en_d;
            pend_q        <= pend_d;
            act_code_q    <= act_code_d;
            act_en_q      <= act_en_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg_code    = seg_q;
    assign frame_start = frame_start_q;

endmodule
